// File: rtl/bus_pkg.sv
// Shared constants and types for the byte-bus arbiter: source indices,
// mux select encodings and the arbiter state type.
package bus_pkg;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  // {sel1, sel0} as seen by the four-way byte mux downstream.
  localparam logic [1:0] SEL_A = 2'b11;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting source found when
// searching upward from ptr, wrapping 3 -> 0.
module rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] idx;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any = |req;
    win = ptr;
    idx = ptr;
    // Walk from the farthest offset back to ptr so the nearest requester wins.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the byte-bus mux selects, with hold limit and a
// single dead turnaround cycle between owners. All outputs are registered.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       bus_valid,
  output logic [1:0] owner
);

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  arb_state_t state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  logic       pick_any;
  logic [1:0] pick_win;
  logic [1:0] win_sel;
  logic [3:0] owner_bit;
  logic       others;
  logic       hold_hit;
  logic       give_up;

  rr_picker u_picker (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .win (pick_win)
  );

  // Select encoding of the incoming winner, loaded together with owner.
  always_comb begin
    win_sel = SEL_A;
    case (pick_win)
      SRC_A:   win_sel = SEL_A;
      SRC_B:   win_sel = SEL_B;
      SRC_C:   win_sel = SEL_C;
      SRC_D:   win_sel = SEL_D;
      default: win_sel = SEL_A;
    endcase
  end

  // Preemption uses strict equality: an owner that ran past the limit
  // alone is not cut off when a competitor shows up later.
  always_comb begin
    owner_bit = 4'b0001 << owner;
    others    = |(req & ~owner_bit);
    hold_hit  = HOLD_EN && (hold_cnt == HOLD_LAST) && others;
    give_up   = !req[owner] || hold_hit;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= SRC_A;
      owner        <= SRC_A;
      hold_cnt     <= 8'd0;
      gnt          <= 4'b0000;
      bus_valid    <= 1'b0;
      {sel1, sel0} <= SEL_A;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (pick_any) begin
            state        <= GRANT;
            owner        <= pick_win;
            ptr          <= pick_win + 2'd1;
            hold_cnt     <= 8'd0;
            gnt          <= 4'b0001 << pick_win;
            bus_valid    <= 1'b1;
            {sel1, sel0} <= win_sel;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (give_up) begin
            state     <= TURN;
            gnt       <= 4'b0000;
            bus_valid <= 1'b0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 4'b0000;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Three arbiters (MAX_HOLD 2, 0, 3) share one request bus; each is checked
// every cycle against an ownership model, plus directed scenario tables.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_h   [3];
  logic       sel0_h  [3];
  logic       sel1_h  [3];
  logic       valid_h [3];
  logic [1:0] owner_h [3];

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(2)) u_dut_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_h[0]), .sel0(sel0_h[0]),
    .sel1(sel1_h[0]), .bus_valid(valid_h[0]), .owner(owner_h[0]));
  bus_arbiter #(.MAX_HOLD(0)) u_dut_h0 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_h[1]), .sel0(sel0_h[1]),
    .sel1(sel1_h[1]), .bus_valid(valid_h[1]), .owner(owner_h[1]));
  bus_arbiter #(.MAX_HOLD(3)) u_dut_h3 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_h[2]), .sel0(sel0_h[2]),
    .sel1(sel1_h[2]), .bus_valid(valid_h[2]), .owner(owner_h[2]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Ownership model: who owns the bus, for how many cycles, where the
  // round-robin search starts next. Dead cycles need no separate state.
  typedef struct {
    bit owned;
    int owner;
    int ptr;
    int cycles;
  } mdl_t;

  mdl_t       m[3];
  int         lim[3] = '{2, 0, 3};
  logic [1:0] sel_tab[4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  function automatic void mdl_reset();
    for (int i = 0; i < 3; i++) m[i] = '{owned: 1'b0, owner: 0, ptr: 0, cycles: 0};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void mdl_step(input int i, input logic [3:0] r);
    int  w;
    bit  rivals;
    if (m[i].owned) begin
      rivals = 1'b0;
      for (int s = 0; s < 4; s++) if (s != m[i].owner && r[s]) rivals = 1'b1;
      if (!r[m[i].owner] || (lim[i] != 0 && m[i].cycles == lim[i] && rivals))
        m[i].owned = 1'b0;
      else
        m[i].cycles++;
    end else begin
      w = rr_pick(r, m[i].ptr);
      if (w >= 0) begin
        m[i].owned  = 1'b1;
        m[i].owner  = w;
        m[i].ptr    = (w + 1) % 4;
        m[i].cycles = 1;
      end
    end
  endfunction

  task automatic check_all();
    logic [3:0] exp_g;
    for (int i = 0; i < 3; i++) begin
      exp_g = m[i].owned ? (4'b0001 << m[i].owner) : 4'b0000;
      check($sformatf("h%0d_gnt", lim[i]), gnt_h[i], exp_g);
      check($sformatf("h%0d_sel", lim[i]), {sel1_h[i], sel0_h[i]}, sel_tab[m[i].owner]);
      check($sformatf("h%0d_valid", lim[i]), valid_h[i], m[i].owned);
      check($sformatf("h%0d_owner", lim[i]), owner_h[i], m[i].owner);
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) mdl_step(i, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    mdl_reset();
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] rot_gnt[13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                              4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
  logic [3:0] pre_gnt[5]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
  logic [3:0] r;

  initial begin
    mdl_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt_h[0], 4'h0);
    check("rst_sel", {sel1_h[0], sel0_h[0]}, 2'b11);
    check("rst_valid", valid_h[0], 1'b0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester A: granted after one edge and held.
    for (int s = 0; s < 4; s++) begin
      step(4'b0001);
      check("a_only_gnt", gnt_h[0], 4'b0001);
      check("a_only_sel", {sel1_h[0], sel0_h[0]}, 2'b11);
      check("a_only_valid", valid_h[0], 1'b1);
    end
    step(4'b0000);
    step(4'b0000);

    // Full contention with a hold limit of 2: rotation A, B, C, D, A.
    do_reset();
    for (int s = 0; s < 13; s++) begin
      step(4'b1111);
      check("rot_gnt", gnt_h[0], rot_gnt[s]);
      if (s % 3 == 0) check("rot_sel", {sel1_h[0], sel0_h[0]}, sel_tab[(s / 3) % 4]);
    end

    // No hold limit: A keeps the bus until it lets go, then C after one dead cycle.
    do_reset();
    for (int s = 0; s < 6; s++) begin
      step(4'b0101);
      check("nolim_hold", gnt_h[1], 4'b0001);
    end
    step(4'b0100);
    check("nolim_turn", gnt_h[1], 4'b0000);
    check("nolim_turn_sel", {sel1_h[1], sel0_h[1]}, 2'b11);
    step(4'b0100);
    check("nolim_c_gnt", gnt_h[1], 4'b0100);
    check("nolim_c_sel", {sel1_h[1], sel0_h[1]}, 2'b01);

    // D alone, drops and re-raises: grant, turn, grant again.
    do_reset();
    step(4'b1000);
    check("d_gnt1", gnt_h[1], 4'b1000);
    step(4'b0000);
    check("d_turn", gnt_h[1], 4'b0000);
    step(4'b1000);
    check("d_gnt2", gnt_h[1], 4'b1000);
    check("d_owner", owner_h[1], 2'd3);
    step(4'b0011);
    step(4'b0011);

    // Asynchronous reset while B owns the bus, then B first from ptr 0.
    do_reset();
    step(4'b0010);
    check("b_owned", gnt_h[0], 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt_h[0], 4'b0000);
    check("async_rst_sel", {sel1_h[0], sel0_h[0]}, 2'b11);
    check("async_rst_valid", valid_h[0], 1'b0);
    mdl_reset();
    #1 rst_n = 1'b1;
    step(4'b1110);
    check("post_rst_b", gnt_h[0], 4'b0010);

    // Release and preemption on the same edge with a limit of 3.
    do_reset();
    for (int s = 0; s < 5; s++) begin
      step((s < 3) ? 4'b0011 : 4'b0010);
      check("pre_rel_gnt", gnt_h[2], pre_gnt[s]);
    end

    // Randomized requests with sticky bits so ownership runs get long.
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
